// File: rtl/ok_dram_pkg.sv
// Shared helpers for the ok_dram FIFO slice: width functions and the registered flag bundle.
package ok_dram_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int ptr_width(input int depth_log2);
      return depth_log2;
   endfunction

   // Count needs one extra bit so that a full FIFO (DEPTH entries) is representable.
   function automatic int count_width(input int depth_log2);
      return clog2(1 << depth_log2) + 1;
   endfunction

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_full;
      logic overflow;
      logic underflow;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RESET = '{empty: 1'b1, default: 1'b0};

endpackage

// File: rtl/ok_dram_nxw.sv
// Distributed RAM, WIDTH x 2**DEPTH_LOG2: one synchronous write port, asynchronous reads at
// the write address (spo) and at an independent read address (dpo), built one bit column at a time.
module ok_dram_nxw #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [WIDTH-1:0]      o_spo,
   output logic [WIDTH-1:0]      o_dpo
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [DEPTH-1:0] r_col;

      always_ff @(posedge clk) begin
         if (i_we) begin
            r_col[i_waddr] <= i_wdata[b];
         end
      end

      assign o_spo[b] = r_col[i_waddr];
      assign o_dpo[b] = r_col[i_raddr];
   end

endmodule

// File: rtl/ok_dram_fifo.sv
// Single-clock FIFO on distributed RAM with count, almost_full and overflow/underflow pulses.
// Define OK_DRAM_FIFO_FWFT_EN for first-word-fall-through; otherwise dout is a registered pop.
module ok_dram_fifo
   import ok_dram_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      din,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = ptr_width(DEPTH_LOG2);
   localparam int CW    = count_width(DEPTH_LOG2);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   fifo_flags_t      r_flags;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_ram_we;
   logic [WIDTH-1:0] w_rd_data;
   logic [WIDTH-1:0] w_spo_unused;

   // Handshake: a read is accepted when rd_en is high and the FIFO holds data; a write is accepted
   // when wr_en is high and a slot is free or is freed by an accepted read on the same edge.
   // Rejected requests are dropped and reported by a one-cycle overflow/underflow pulse.
   always_comb begin
      w_rd_acc    = rd_en & ~r_flags.empty;
      w_wr_acc    = wr_en & (~r_flags.full | w_rd_acc);
      w_count_nxt = r_count;
      if (w_wr_acc & ~w_rd_acc) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_rd_acc & ~w_wr_acc) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   assign w_ram_we = w_wr_acc & ~reset;

   ok_dram_nxw #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (din),
      .i_raddr (r_rd_ptr),
      .o_spo   (w_spo_unused),
      .o_dpo   (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_flags  <= FLAGS_RESET;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count             <= w_count_nxt;
         r_flags.empty       <= (w_count_nxt == '0);
         r_flags.full        <= (w_count_nxt == CW'(DEPTH));
         r_flags.almost_full <= (w_count_nxt >= CW'(AF_LEVEL));
         r_flags.overflow    <= wr_en & ~w_wr_acc;
         r_flags.underflow   <= rd_en & ~w_rd_acc;
      end
   end

`ifdef OK_DRAM_FIFO_FWFT_EN
   assign dout = w_rd_data;
`else
   logic [WIDTH-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout <= '0;
      end else if (w_rd_acc) begin
         r_dout <= w_rd_data;
      end
   end

   assign dout = r_dout;
`endif

   assign empty       = r_flags.empty;
   assign full        = r_flags.full;
   assign almost_full = r_flags.almost_full;
   assign overflow    = r_flags.overflow;
   assign underflow   = r_flags.underflow;
   assign count       = r_count;

endmodule

// File: tb/tb_ok_dram_fifo.sv
// Bench for ok_dram_fifo: two instances (8x16 default, 32x4 with AF_LEVEL=3) share the stimulus;
// a queue-based reference model predicts data and flags, a monitor compares after each edge.
module tb_ok_dram_fifo;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] din;

   logic [7:0]  a_dout;
   logic        a_empty, a_full, a_af, a_ovf, a_unf;
   logic [4:0]  a_count;

   logic [31:0] b_dout;
   logic        b_empty, b_full, b_af, b_ovf, b_unf;
   logic [2:0]  b_count;

   ok_dram_fifo u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .din         (din[7:0]),
      .rd_en       (rd_en),
      .dout        (a_dout),
      .empty       (a_empty),
      .full        (a_full),
      .almost_full (a_af),
      .count       (a_count),
      .overflow    (a_ovf),
      .underflow   (a_unf)
   );

   ok_dram_fifo #(
      .WIDTH      (32),
      .DEPTH_LOG2 (2),
      .AF_LEVEL   (3)
   ) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .din         (din),
      .rd_en       (rd_en),
      .dout        (b_dout),
      .empty       (b_empty),
      .full        (b_full),
      .almost_full (b_af),
      .count       (b_count),
      .overflow    (b_ovf),
      .underflow   (b_unf)
   );

   // ---------------- selected-DUT view ----------------
   bit          sel;
   bit          sel_nxt;
   int          depth;
   int          af_level;
   logic [31:0] mask;

   logic [31:0] m_dout;
   logic        m_empty, m_full, m_af, m_ovf, m_unf;
   int          m_count;

   always_comb begin
      m_dout  = {24'h0, a_dout};
      m_empty = a_empty;
      m_full  = a_full;
      m_af    = a_af;
      m_ovf   = a_ovf;
      m_unf   = a_unf;
      m_count = int'(a_count);
      if (sel) begin
         m_dout  = b_dout;
         m_empty = b_empty;
         m_full  = b_full;
         m_af    = b_af;
         m_ovf   = b_ovf;
         m_unf   = b_unf;
         m_count = int'(b_count);
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int count;
      bit ovf;
      bit unf;
   } st_t;

   logic [31:0] exp_q[$];
   logic [31:0] model_q[$];
   st_t         st_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- driver ----------------
   // One call = one modelled clock edge; inputs change on the falling edge.
   task automatic drive(input bit rst, input bit wr, input bit rd, input logic [31:0] d);
      st_t s;
      int  size;
      bit  ra;
      bit  wa;
      @(negedge clk);
      sel      = sel_nxt;
      depth    = sel ? 4 : 16;
      af_level = sel ? 3 : 14;
      mask     = sel ? 32'hFFFF_FFFF : 32'h0000_00FF;
      reset    = rst;
      wr_en    = wr;
      rd_en    = rd;
      din      = d;
      if (rst) begin
         model_q.delete();
         s.count = 0;
         s.ovf   = 1'b0;
         s.unf   = 1'b0;
      end else begin
         size = model_q.size();
         ra   = rd && (size > 0);
         wa   = wr && ((size < depth) || ra);
         if (ra) exp_q.push_back(model_q.pop_front());
         if (wa) model_q.push_back(d & mask);
         s.count = model_q.size();
         s.ovf   = wr && !wa;
         s.unf   = rd && (size == 0);
      end
      st_q.push_back(s);
   endtask

   // ---------------- monitor ----------------
   logic        pre_acc;
   logic [31:0] pre_dout;
   st_t         s_mon;
   logic [31:0] e_mon;

   always begin
      @(posedge clk);
      pre_acc  = rd_en && !m_empty && !reset;
      pre_dout = m_dout;
      #1;
      if (st_q.size() > 0) begin
         s_mon = st_q.pop_front();
         check("count",       m_count, s_mon.count);
         check("empty",       m_empty, s_mon.count == 0);
         check("full",        m_full,  s_mon.count == depth);
         check("almost_full", m_af,    s_mon.count >= af_level);
         check("overflow",    m_ovf,   s_mon.ovf);
         check("underflow",   m_unf,   s_mon.unf);
      end
      if (pre_acc) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL read_data: read accepted with no expected word at %0t", $time);
         end else begin
            e_mon = exp_q.pop_front();
`ifdef OK_DRAM_FIFO_FWFT_EN
            check("read_data", pre_dout, e_mon);
`else
            check("read_data", m_dout, e_mon);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      din      = '0;
      sel      = 1'b0;
      sel_nxt  = 1'b0;
      depth    = 16;
      af_level = 14;
      mask     = 32'hFF;

      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
`ifndef OK_DRAM_FIFO_FWFT_EN
      @(posedge clk);
      #2;
      check("dout_reset", m_dout, 32'h0);
`endif

      // Fill 0x01..0x10, overflow attempt, drain, then underflow.
      for (int i = 1; i <= 16; i++) drive(0, 1, 0, 32'(i));
      drive(0, 1, 0, 32'hAA);
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);

      // Full FIFO with concurrent push/pop: pointers wrap, count holds at 16.
      for (int i = 0; i < 16; i++) drive(0, 1, 0, 32'(8'h20 + i));
      for (int i = 0; i < 40; i++) drive(0, 1, 1, 32'(8'h30 + i));
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);

      // Read+write on empty: underflow, write still lands.
      drive(0, 1, 1, 32'h5C);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);

      // Reset mid-burst with requests asserted; old data must vanish.
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 32'(8'h40 + i));
      drive(1, 1, 1, 32'h77);
      drive(0, 1, 0, 32'h99);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);

      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 50, $urandom);

      // 32-bit x 4 instance.
      sel_nxt = 1'b1;
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 32'hDEAD_BEEF + 32'(i));
      drive(0, 1, 0, 32'h1234_5678);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
      for (int i = 0; i < 1000; i++)
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 55, $urandom);

      for (int i = 0; i < 8 && model_q.size() > 0; i++) drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      @(posedge clk);
      #2;
      check("exp_q_drained", exp_q.size(), 0);
      check("st_q_drained", st_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ok_dram_fifo.md
# ok_dram_fifo

Parametrised single-clock FIFO built on distributed dual-port RAM. Successor to the fixed 16x8 distributed-RAM primitive wrapper: generalised in width and depth, with pointer management, occupancy count, almost-full and overflow/underflow flags. Used as a shallow elastic buffer between host-interface endpoints and pixel/I2C datapaths inside one clock domain.

## Interface
- WIDTH, 8, data width in bits (1..64)
- DEPTH_LOG2, 4, log2 of storage entries; DEPTH = 2**DEPTH_LOG2 (2..6)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request (pop)
- dout  out  WIDTH  read data
- empty  out  1  no entries stored
- full  out  1  DEPTH entries stored
- almost_full  out  1  count >= AF_LEVEL
- count  out  DEPTH_LOG2+1  entries stored, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Reset (sampled high at an edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, registered dout=0. RAM contents not cleared.
- Pointers DEPTH_LOG2 bits, increment modulo DEPTH (natural wrap DEPTH-1 -> 0).
- Accepted write: wr_en & (!full | rd_en accepted). RAM[wr_ptr] <= din, wr_ptr++.
- Accepted read: rd_en & !empty. rd_ptr++.
- Write when full and no accepted read: dropped, no state change, overflow=1 next cycle.
- Read when empty: ignored, underflow=1 next cycle; a simultaneous write to the empty FIFO is still accepted (no bypass of the read).
- Simultaneous accepted read and write: count unchanged; valid at any occupancy including full (slot freed same edge).
- count: +1 write only, -1 read only, else hold. empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL); all registered, derived from next count.
- Data order strictly FIFO; no reordering, no drops except overflow case.
- reset asserted mid-operation discards all stored entries at that edge; wr_en/rd_en in that cycle ignored, no flag pulses.

## Timing
- Write accepted at edge N: count/empty/full updated after edge N (visible cycle N+1).
- Read latency depends on configuration (below); flags always update one edge after the accepting edge.
- overflow/underflow: asserted exactly one cycle following the offending edge; back-to-back offences give continuous high.
- No combinational path from wr_en/rd_en to any output.

## Configuration
- OK_DRAM_FIFO_FWFT_EN defined: first-word-fall-through. dout = RAM[rd_ptr] via asynchronous read port; head word valid whenever empty=0 (first word visible cycle N+1 after write at edge N); rd_en acknowledges current dout. dout undefined while empty.
- Not defined: standard mode. dout is a register loaded with RAM[rd_ptr] on an accepted read at edge N, valid cycle N+1, held until next accepted read; reset value 0.

## Structure
- Package ok_dram_pkg: clog2 function, ok_dram_fifo count/pointer width constants helper, flag-bundle typedef (empty, full, almost_full, overflow, underflow).
- One sub-module: ok_dram_nxw — parametrised (WIDTH, DEPTH_LOG2) distributed RAM, one synchronous write port, two asynchronous read ports (write address port and dual read port), generated per bit.
- FIFO control (pointers, count, flags, dout register) in ok_dram_fifo.

## Test plan
- Reset then idle: count=0, empty=1, full=0, almost_full=0, flags 0, registered dout=0x00.
- Default params, write 0x01..0x10 (16 words): full=1 after 16th edge, almost_full=1 after 14th; 17th write 0xAA -> overflow pulse, count stays 16; read all 16 -> 0x01..0x10 in order, empty=1.
- Fill to 16, then assert wr_en and rd_en together 40 cycles with incrementing data: count stays 16, no overflow, pointers wrap twice, output sequence contiguous.
- Empty FIFO, rd_en with wr_en din=0x5C: underflow pulse, count=1; next read returns 0x5C (FWFT: dout=0x5C cycle after write; standard: cycle after read).
- Write 5 words, assert reset mid-burst: count=0, empty=1 next cycle, no flag pulses; subsequent write/read returns new data only.
- WIDTH=32, DEPTH_LOG2=2, AF_LEVEL=3: 4 writes 0xDEADBEEF.. -> full after 4, almost_full after 3; random push/pop 1000 cycles vs scoreboard, zero mismatches.
